// File: rtl/trash_core.sv
// trash_core: 8-bit micro-sequencer with a loadable program store, register file and scratchpad.
// Define TRASH_CORE_RETIRE_CNT_EN to build the saturating retired-instruction counter.
module trash_core #(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned NREG       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_en,
  input  logic                          prog_valid,
  input  logic [15:0]                   prog_data,
  input  logic                          run,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  output logic                          halted,
  output logic                          busy,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [15:0]                   retired
);

  localparam int unsigned PW = $clog2(PROG_DEPTH);
  localparam int unsigned MW = $clog2(MEM_DEPTH);
  localparam int unsigned RW = $clog2(NREG);
  localparam logic [PW-1:0] PcOne = 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] load_ptr_q, load_ptr_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [15:0] pmem [PROG_DEPTH];
  logic [7:0]  regs_q [NREG];
  logic [7:0]  dmem_q [MEM_DEPTH];

  logic          pmem_we, reg_we, mem_we, exec;
  logic [7:0]    reg_wdata, alu_res;
  logic [15:0]   instr;
  logic [3:0]    op, fn;
  logic [7:0]    imm;
  logic [RW-1:0] ra_idx, rb_idx;
  logic [MW-1:0] maddr;
  logic [7:0]    ra_val, rb_val;

  // Fetch is combinational straight out of the program array.
  assign instr  = pmem[pc_q];
  assign op     = instr[15:12];
  assign fn     = instr[3:0];
  assign imm    = instr[7:0];
  assign ra_idx = instr[8 +: RW];
  assign rb_idx = instr[4 +: RW];
  assign maddr  = imm[MW-1:0];
  assign ra_val = regs_q[ra_idx];
  assign rb_val = regs_q[rb_idx];

  always_comb begin
    alu_res = ra_val;
    case (fn)
      4'h0: alu_res = ra_val + rb_val;
      4'h1: alu_res = ra_val - rb_val;
      4'h2: alu_res = ra_val & rb_val;
      4'h3: alu_res = ra_val | rb_val;
      4'h4: alu_res = ra_val ^ rb_val;
      4'h5: alu_res = ~ra_val;
      4'h6: alu_res = {1'b0, ra_val[7:1]};
      4'h7: alu_res = {ra_val[6:0], 1'b0};
      4'h8: alu_res = ra_val + 8'd1;
      4'h9: alu_res = ra_val - 8'd1;
      default: alu_res = ra_val;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_ptr_d  = load_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pmem_we     = 1'b0;
    reg_we      = 1'b0;
    reg_wdata   = 8'h00;
    mem_we      = 1'b0;
    exec        = 1'b0;
    case (state_q)
      StIdle: begin
        if (prog_en) begin
          state_d    = StLoad;
          load_ptr_d = '0;
        end else if (run) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StLoad: begin
        if (prog_valid) begin
          pmem_we    = 1'b1;
          load_ptr_d = load_ptr_q + PcOne;
        end
        if (!prog_en) state_d = StIdle;
      end
      StRun: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          exec = 1'b1;
          pc_d = pc_q + PcOne;
          case (op)
            4'h1: begin
              reg_we    = 1'b1;
              reg_wdata = imm;
            end
            4'h2: begin
              reg_we    = 1'b1;
              reg_wdata = alu_res;
            end
            4'h3: mem_we = 1'b1;
            4'h4: begin
              reg_we    = 1'b1;
              reg_wdata = dmem_q[maddr];
            end
            4'h5: pc_d = imm[PW-1:0];
            4'h6: if (ra_val == 8'h00) pc_d = imm[PW-1:0];
            4'h7: begin
              out_data_d  = ra_val;
              out_valid_d = 1'b1;
            end
            4'h8: begin
              state_d = StHalt;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      StHalt: if (!run) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      load_ptr_q  <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_ptr_q  <= load_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Program store has no reset; a reset edge must still suppress a pending write.
  always_ff @(posedge clk) begin
    if (rst_n && pmem_we) pmem[load_ptr_q] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else if (reg_we) begin
      regs_q[ra_idx] <= reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) dmem_q[i] <= 8'h00;
    end else if (mem_we) begin
      dmem_q[maddr] <= ra_val;
    end
  end

`ifdef TRASH_CORE_RETIRE_CNT_EN
  logic [15:0] retired_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
    end else if (state_q == StIdle && !prog_en && run) begin
      retired_q <= 16'h0000;
    end else if (exec && retired_q != 16'hFFFF) begin
      retired_q <= retired_q + 16'd1;
    end
  end
  assign retired = retired_q;
`else
  logic unused_exec;
  assign unused_exec = exec;
  assign retired     = 16'h0000;
`endif

  logic unused_instr;
  assign unused_instr = ^instr;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == StHalt);
  assign busy      = (state_q == StRun);
  assign pc        = pc_q;

endmodule
